// File: rtl/dh_privkey_gen.sv
// Diffie-Hellman private exponent generator: a 128-bit Fibonacci LFSR is sampled
// WIDTH bits at a time and candidates outside [2, prime-2] are rejected and redrawn.
module dh_privkey_gen #(
  parameter int           WIDTH     = 100,
  parameter logic [127:0] LFSR_SEED = 128'h1,
  parameter int           MAX_TRIES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_we,
  input  logic [127:0]     seed,
  input  logic             ent_in,
  input  logic             start,
  input  logic [WIDTH-1:0] prime,
  output logic             busy,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [WIDTH:0]   key,
  output logic             err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MASK  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_FAIL  = 3'd5;

  logic [2:0]       state;
  logic [127:0]     lfsr;
  logic [WIDTH-1:0] prime_r;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic [TRY_W-1:0] tries;
  logic             lfsr_fb;
  logic [WIDTH-1:0] cand_m;

  // Smear the leading one of p down to bit 0.
  function automatic logic [WIDTH-1:0] msb_mask(input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] m;
    m = p;
    for (int i = 1; i < WIDTH; i++) begin
      m = m | (m >> 1);
    end
    return m;
  endfunction

  function automatic logic in_range(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] p);
    return (c >= WIDTH'(2)) && (c <= p - WIDTH'(2));
  endfunction

  assign lfsr_fb   = lfsr[127] ^ lfsr[125] ^ lfsr[100] ^ lfsr[98] ^ ent_in;
  assign cand_m    = cand & mask;
  assign busy      = (state != S_IDLE);
  assign key_valid = (state == S_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      lfsr    <= LFSR_SEED;
      prime_r <= '0;
      mask    <= '0;
      cand    <= '0;
      cnt     <= '0;
      tries   <= '0;
      key     <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            prime_r <= prime;
            err     <= 1'b0;
            tries   <= '0;
            state   <= S_MASK;
          end else if (seed_we) begin
            lfsr <= (seed == 128'h0) ? LFSR_SEED : seed;
          end
        end
        S_MASK: begin
          mask <= msb_mask(prime_r);
          // Below 5 the range [2, prime-2] is empty, so fail without drawing.
          if (prime_r < WIDTH'(5)) begin
            err   <= 1'b1;
            state <= S_FAIL;
          end else begin
            cand  <= '0;
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          cand <= {cand[WIDTH-2:0], lfsr[127]};
          lfsr <= {lfsr[126:0], lfsr_fb};
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= S_CHECK;
        end
        S_CHECK: begin
          if (in_range(cand_m, prime_r)) begin
            key   <= {1'b0, cand_m};
            state <= S_HOLD;
          end else if (tries == TRY_LAST) begin
            err   <= 1'b1;
            state <= S_FAIL;
          end else begin
            tries <= tries + TRY_W'(1);
            cand  <= '0;
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_HOLD: begin
          if (key_ready) state <= S_IDLE;
        end
        S_FAIL: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
